// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back encodings: result-source selects, load funct3 codes, buffer types.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package rv32i_pkg;

  // Result source select; 2'b11 is reserved and handled like the ALU path.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  // Load width / sign codes carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

  // One buffered write-back entry.
  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        trap;
  } wb_entry_t;

  // Halfword loads need an even address, word loads a word-aligned one.
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_fmt.sv
// Extracts the addressed byte/halfword from an aligned load word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_fmt
  import rv32i_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection by low address bits, then extension by load type.
  always_comb begin
    byte_sel = i_data[7:0];
    case (i_addr_lo)
      2'd0: byte_sel = i_data[7:0];
      2'd1: byte_sel = i_data[15:8];
      2'd2: byte_sel = i_data[23:16];
      2'd3: byte_sel = i_data[31:24];
      default: byte_sel = i_data[7:0];
    endcase
    half_sel = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];

    o_data = 32'h0;
    case (i_funct3)
      F3_LB:   o_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   o_data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   o_data = i_data;
      F3_LBU:  o_data = {24'h0, byte_sel};
      F3_LHU:  o_data = {16'h0, half_sel};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: single-entry buffer between MEM and the register file, formats results, counts retires.
// Latency: a write reaches the register file 1 cycle after acceptance when not held.
// Backpressure: o_ready drops only while the buffer is FULL and i_hold is high.
module wb_unit
  import rv32i_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_rd_wen,
  input  logic [4:0]          i_rd_waddr,
  input  logic [1:0]          i_sel,
  input  logic [31:0]         i_alu_result,
  input  logic [31:0]         i_pc,
  input  logic [31:0]         i_load_data,
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_hold,
  input  logic                i_flush,
  output logic                o_rd_wen,
  output logic [4:0]          o_rd_waddr,
  output logic [31:0]         o_rd_wdata,
  output logic                o_trap,
  output logic [31:0]         o_pending,
  output logic [RETIRE_W-1:0] o_retire_count
);

  wb_state_e          state_q, state_d;
  wb_entry_t          entry_q, entry_d;
  wb_entry_t          entry_new;
  logic [RETIRE_W-1:0] retire_q;
  logic [31:0]        load_val;
  logic [31:0]        result;
  logic               full;
  logic               accept;
  logic               drain;
  logic               retire_en;
  logic               trap_new;

  load_fmt u_load_fmt (
    .i_data    (i_load_data),
    .i_funct3  (i_funct3),
    .i_addr_lo (i_addr_lo),
    .o_data    (load_val)
  );

  assign full      = (state_q == ST_FULL);
  assign o_ready   = !full || !i_hold;
  assign accept    = i_valid && o_ready;
  assign drain     = full && !i_hold;
  // A flushed entry leaves the buffer without retiring.
  assign retire_en = drain && !i_flush;

  // Select and format the incoming result; misaligned loads are captured with the write suppressed.
  always_comb begin
    result = i_alu_result;
    case (i_sel)
      SEL_ALU:  result = i_alu_result;
      SEL_LOAD: result = load_val;
      SEL_PC4:  result = i_pc + 32'd4;
      default:  result = i_alu_result;
    endcase
    trap_new        = (i_sel == SEL_LOAD) && load_misaligned(i_funct3, i_addr_lo);
    entry_new.wen   = i_rd_wen && !trap_new;
    entry_new.waddr = i_rd_waddr;
    entry_new.wdata = result;
    entry_new.trap  = trap_new;
  end

  // Buffer next-state and register-file/trap/hazard outputs.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    o_rd_wen   = 1'b0;
    o_trap     = 1'b0;
    o_pending  = 32'h0;
    o_rd_waddr = entry_q.waddr;
    o_rd_wdata = entry_q.wdata;

    if (i_flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      entry_d = entry_new;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end

    o_rd_wen = retire_en && entry_q.wen && (entry_q.waddr != 5'd0);
    o_trap   = retire_en && entry_q.trap;
    if (full && entry_q.wen && (entry_q.waddr != 5'd0)) begin
      o_pending = 32'd1 << entry_q.waddr;
    end
  end

  // Buffer state and contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retire_q <= '0;
    end else if (retire_en) begin
      retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  assign o_retire_count = retire_q;

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        rd_wen_in;
  logic [4:0]  rd_waddr_in;
  logic [1:0]  sel;
  logic [31:0] alu;
  logic [31:0] pc;
  logic [31:0] ld;
  logic [2:0]  f3;
  logic [1:0]  alo;
  logic        hold;
  logic        flush;
  logic        rd_wen;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        trap;
  logic [31:0] pending;
  logic [31:0] retire;

  wb_unit #(.RETIRE_W(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_rd_wen       (rd_wen_in),
    .i_rd_waddr     (rd_waddr_in),
    .i_sel          (sel),
    .i_alu_result   (alu),
    .i_pc           (pc),
    .i_load_data    (ld),
    .i_funct3       (f3),
    .i_addr_lo      (alo),
    .i_hold         (hold),
    .i_flush        (flush),
    .o_rd_wen       (rd_wen),
    .o_rd_waddr     (rd_waddr),
    .o_rd_wdata     (rd_wdata),
    .o_trap         (trap),
    .o_pending      (pending),
    .o_retire_count (retire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] ld;
    logic [4:0]  wa;
    logic [31:0] exp_d;
    logic        exp_trap;
  } vec_t;

  vec_t        vecs [12];
  logic [36:0] sb [$];
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_retire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Negedge sample point; any register-file write seen here is matched against the scoreboard.
  task automatic at_neg();
    logic [36:0] e;
    @(negedge clk);
    if (rd_wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", {27'h0, rd_waddr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_waddr", {27'h0, rd_waddr}, {27'h0, e[36:32]});
        check("sb_wdata", rd_wdata, e[31:0]);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] wa, input logic [1:0] s, input logic [2:0] fn,
                       input logic [1:0] a, input logic [31:0] al, input logic [31:0] p, input logic [31:0] d);
    valid       = v;
    rd_wen_in   = 1'b1;
    rd_waddr_in = wa;
    sel         = s;
    f3          = fn;
    alo         = a;
    alu         = al;
    pc          = p;
    ld          = d;
  endtask

  initial begin
    logic        exp_wr;
    logic [31:0] exp_pend;
    clk = 1'b0; rst = 1'b0; valid = 1'b0; rd_wen_in = 1'b0; rd_waddr_in = 5'd0;
    sel = 2'b00; alu = 32'h0; pc = 32'h0; ld = 32'h0; f3 = 3'b0; alo = 2'b0;
    hold = 1'b0; flush = 1'b0;
    n_checks = 0; n_fail = 0; exp_retire = 32'h0;

    //               sel    f3      alo    alu            pc             ld             wa     exp           trap
    vecs[0]  = '{2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'h0,         32'h0,         5'd5,  32'h1234_5678, 1'b0};
    vecs[1]  = '{2'b01, 3'b000, 2'd1, 32'h0,         32'h0,         32'h0000_8000, 5'd6,  32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{2'b01, 3'b101, 2'd2, 32'h0,         32'h0,         32'hBEEF_0000, 5'd7,  32'h0000_BEEF, 1'b0};
    vecs[3]  = '{2'b01, 3'b010, 2'd0, 32'h0,         32'h0,         32'hCAFE_F00D, 5'd8,  32'hCAFE_F00D, 1'b0};
    vecs[4]  = '{2'b10, 3'b000, 2'd0, 32'h0,         32'hFFFF_FFFC, 32'h0,         5'd9,  32'h0000_0000, 1'b0};
    vecs[5]  = '{2'b11, 3'b000, 2'd0, 32'hA5A5_A5A5, 32'h0,         32'h0,         5'd10, 32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{2'b01, 3'b100, 2'd3, 32'h0,         32'h0,         32'h80FF_FFFF, 5'd11, 32'h0000_0080, 1'b0};
    vecs[7]  = '{2'b01, 3'b001, 2'd2, 32'h0,         32'h0,         32'h8001_0000, 5'd12, 32'hFFFF_8001, 1'b0};
    vecs[8]  = '{2'b01, 3'b011, 2'd0, 32'h0,         32'h0,         32'h7777_7777, 5'd13, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b01, 3'b010, 2'd2, 32'h0,         32'h0,         32'h1111_2222, 5'd14, 32'h0,         1'b1};
    vecs[10] = '{2'b01, 3'b001, 2'd1, 32'h0,         32'h0,         32'h3333_4444, 5'd15, 32'h0,         1'b1};
    vecs[11] = '{2'b00, 3'b000, 2'd0, 32'h5555_AAAA, 32'h0,         32'h0,         5'd0,  32'h5555_AAAA, 1'b0};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_ready",   {31'h0, ready},  32'd1);
    check("rst_wen",     {31'h0, rd_wen}, 32'd0);
    check("rst_trap",    {31'h0, trap},   32'd0);
    check("rst_pending", pending,         32'd0);
    check("rst_retire",  retire,          32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Table: accept, check the write one cycle later, then the retire after the drain
    for (int i = 0; i < 12; i++) begin
      tick();
      drive(1'b1, vecs[i].wa, vecs[i].sel, vecs[i].f3, vecs[i].alo, vecs[i].alu, vecs[i].pc, vecs[i].ld);
      exp_wr   = !vecs[i].exp_trap && (vecs[i].wa != 5'd0);
      exp_pend = exp_wr ? (32'd1 << vecs[i].wa) : 32'd0;
      if (exp_wr) sb.push_back({vecs[i].wa, vecs[i].exp_d});
      tick();
      valid = 1'b0;
      at_neg();
      check($sformatf("v%0d_wen", i),     {31'h0, rd_wen}, {31'h0, exp_wr});
      check($sformatf("v%0d_trap", i),    {31'h0, trap},   {31'h0, vecs[i].exp_trap});
      check($sformatf("v%0d_pending", i), pending,         exp_pend);
      check($sformatf("v%0d_ready", i),   {31'h0, ready},  32'd1);
      if (exp_wr) begin
        check($sformatf("v%0d_waddr", i), {27'h0, rd_waddr}, {27'h0, vecs[i].wa});
        check($sformatf("v%0d_wdata", i), rd_wdata,          vecs[i].exp_d);
      end
      tick();
      exp_retire = exp_retire + 32'd1;
      at_neg();
      check($sformatf("v%0d_retire", i),     retire,          exp_retire);
      check($sformatf("v%0d_trap_gone", i),  {31'h0, trap},   32'd0);
      check($sformatf("v%0d_wen_gone", i),   {31'h0, rd_wen}, 32'd0);
    end

    // Hold for three cycles while FULL, then release: exactly one write
    tick();
    drive(1'b1, 5'd3, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    sb.push_back({5'd3, 32'hDEAD_BEEF});
    tick();
    valid = 1'b0;
    hold  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check($sformatf("hold%0d_ready", c),   {31'h0, ready},  32'd0);
      check($sformatf("hold%0d_pending", c), pending,         32'h0000_0008);
      check($sformatf("hold%0d_wen", c),     {31'h0, rd_wen}, 32'd0);
      tick();
    end
    hold = 1'b0;
    at_neg();
    check("hold_release_wen", {31'h0, rd_wen}, 32'd1);
    tick();
    exp_retire = exp_retire + 32'd1;
    at_neg();
    check("hold_once_wen", {31'h0, rd_wen}, 32'd0);
    check("hold_retire",   retire,          exp_retire);

    // Flush while FULL with a simultaneous valid: both entries dropped, nothing retires
    tick();
    drive(1'b1, 5'd4, 2'b00, 3'b000, 2'd0, 32'h1111_1111, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 2'b00, 3'b000, 2'd0, 32'h2222_2222, 32'h0, 32'h0);
    flush = 1'b1;
    at_neg();
    check("flush_wen",     {31'h0, rd_wen}, 32'd0);
    check("flush_pending", pending,         32'h0000_0010);
    tick();
    flush = 1'b0;
    valid = 1'b0;
    at_neg();
    check("flush_empty_pending", pending,         32'd0);
    check("flush_empty_wen",     {31'h0, rd_wen}, 32'd0);
    check("flush_retire",        retire,          exp_retire);

    // Asynchronous reset mid-cycle while FULL and held
    tick();
    drive(1'b1, 5'd15, 2'b00, 3'b000, 2'd0, 32'h3333_3333, 32'h0, 32'h0);
    tick();
    valid = 1'b0;
    hold  = 1'b1;
    at_neg();
    check("prerst_pending", pending,        32'h0000_8000);
    check("prerst_ready",   {31'h0, ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pending", pending,         32'd0);
    check("arst_wen",     {31'h0, rd_wen}, 32'd0);
    check("arst_ready",   {31'h0, ready},  32'd1);
    check("arst_retire",  retire,          32'd0);
    tick();
    hold = 1'b0;
    at_neg();
    check("arst_nowrite", {31'h0, rd_wen}, 32'd0);
    rst = 1'b0;

    // Retire counter preloaded to all-ones wraps to zero on the next retire
    tick();
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    check("preload_retire", retire, 32'hFFFF_FFFF);
    drive(1'b1, 5'd1, 2'b00, 3'b000, 2'd0, 32'h4444_4444, 32'h0, 32'h0);
    sb.push_back({5'd1, 32'h4444_4444});
    tick();
    valid = 1'b0;
    at_neg();
    check("wrap_wen", {31'h0, rd_wen}, 32'd1);
    tick();
    at_neg();
    check("wrap_retire", retire, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32: width of the retire counter.
REQ-002 SHALL have i_clk, input, 1: the single clock; every register changes on its rising edge.
REQ-003 SHALL have i_rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have i_valid, input, 1, and o_ready, output, 1: upstream (MEM stage) handshake.
REQ-005 SHALL have i_rd_wen, input, 1, and i_rd_waddr, input, 5: destination write request and register index.
REQ-006 SHALL have i_sel, input, 2: result source; 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved, treated as ALU.
REQ-007 SHALL have i_alu_result, input, 32, and i_pc, input, 32: ALU result and instruction PC.
REQ-008 SHALL have i_load_data, input, 32: raw aligned data word returned by memory.
REQ-009 SHALL have i_funct3, input, 3, and i_addr_lo, input, 2: load width/sign code and low address bits.
REQ-010 SHALL have i_hold, input, 1: downstream freeze; no write is issued while it is high.
REQ-011 SHALL have i_flush, input, 1: discards the buffered entry.
REQ-012 SHALL have o_rd_wen, output, 1; o_rd_waddr, output, 5; o_rd_wdata, output, 32: register-file write port.
REQ-013 SHALL have o_trap, output, 1: one-cycle pulse flagging a misaligned load.
REQ-014 SHALL have o_pending, output, 32: one-hot mask of the register held in the buffer, for hazard detection.
REQ-015 SHALL have o_retire_count, output, RETIRE_W: count of retired instructions.

Function
REQ-016 SHALL contain a single-entry buffer with states EMPTY and FULL.
REQ-017 o_ready SHALL equal (state == EMPTY) or (i_hold == 0).
REQ-018 The buffer SHALL accept on the rising edge where i_valid and o_ready are both high; the entry drains on any FULL cycle with i_hold low.
REQ-019 Transitions SHALL be: EMPTY to FULL on accept; FULL to EMPTY on drain without accept; FULL to FULL on simultaneous drain and accept.
REQ-020 SHALL format the result before it is registered: ALU passes through; PC+4 is computed modulo 2^32; load selects byte/half by i_addr_lo.
REQ-021 Load funct3 decoding SHALL be: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend); other codes yield 0.
REQ-022 Misalignment SHALL be: LH/LHU with i_addr_lo[0]=1, or LW with i_addr_lo != 0; the entry is then captured with its write suppressed and trap set.
REQ-023 o_rd_wen SHALL equal FULL and !i_hold and !i_flush and wen_q and (waddr_q != 0); o_rd_waddr and o_rd_wdata are driven from the buffer.
REQ-024 Writes SHALL reach the register file exactly 1 cycle after acceptance when i_hold is low.
REQ-025 o_trap SHALL pulse on the draining cycle of a trapped entry; an accompanying flush suppresses it.
REQ-026 o_pending SHALL have bit waddr_q set when FULL and wen_q and waddr_q != 0; otherwise it is 0.
REQ-027 i_flush SHALL force the next state to EMPTY, ignore a same-cycle accept, and suppress both the write and the retire of the buffered entry.
REQ-028 o_retire_count SHALL increment by 1 per drained, unflushed entry, trapped entries included, and wrap at 2^RETIRE_W.

Reset
REQ-029 While i_rst is high, state SHALL be EMPTY, all buffer fields 0, and o_retire_count 0.
REQ-030 While i_rst is high, o_rd_wen, o_trap and o_pending SHALL be 0; o_ready follows REQ-017 and is therefore 1.
REQ-031 Reset asserted mid-operation SHALL drop the buffered entry with no write issued.

Structure
REQ-032 The i_sel encodings and the load funct3 constants SHALL live in the shared package rv32i_pkg.
REQ-033 Load extraction and extension SHALL be a combinational sub-module named load_fmt.

Verification
REQ-034 Bench SHALL cover: accept ALU 0x1234_5678 to x5, hold low -> next cycle o_rd_wen=1, waddr=5, wdata=0x1234_5678, retire 0 to 1.
REQ-035 Bench SHALL cover: LB with load_data 0x0000_8000, addr_lo=1 -> wdata=0xFFFF_FF80; LHU with addr_lo=2 on 0xBEEF_0000 -> 0x0000_BEEF.
REQ-036 Bench SHALL cover: LW with addr_lo=2 -> o_trap pulses 1 cycle, o_rd_wen stays 0, retire increments.
REQ-037 Bench SHALL cover: i_hold high 3 cycles while FULL -> o_ready=0, o_pending bit set, no write; on release the write occurs once.
REQ-038 Bench SHALL cover: a write to x0 -> o_rd_wen=0 and o_pending=0; flush while FULL with a simultaneous valid -> EMPTY, no write, retire unchanged.
REQ-039 Bench SHALL cover: i_rst asserted asynchronously mid-cycle while FULL -> outputs clear immediately; retire counter preloaded to 2^32-1 wraps to 0 on the next retire.
